sipo: RTL and testbench

Serial-in, parallel-out deserializer. It accepts one qualified serial bit per clock, assembles DATA_WIDTH bits into a word, and presents the word on a parallel output through a single-entry holding register with a valid/ready handshake. It sits on the receive side of the serial links driven by the team's parallel-in/serial-out shifter, so its bit-order options match that shifter's. A sticky overrun flag records any word lost to downstream backpressure.

---
 rtl/sipo.sv | 109 ++++++++++
 tb/tb_sipo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo.sv
// Serial-in, parallel-out deserializer with a single-entry valid/ready holding
// register and a sticky overrun flag for words dropped under backpressure.
module sipo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter string       DIRECTION  = "msb_first"
) (
  input  logic                  clk_i,
  input  logic                  a_rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  data_valid_i,
  input  logic                  data_i,
  input  logic                  ready_i,
  output logic                  data_valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  data_q, data_d;
  logic          vld_q, vld_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d;

  logic [W-1:0]  shifted_c;
  logic          accept_c;
  logic          last_c;
  logic          word_done_c;
  logic          hold_free_c;

  // Parameter legality and bit-order selection, resolved at elaboration.
  generate
    if (W < 2 || !(DIRECTION == "msb_first" || DIRECTION == "lsb_first")) begin : g_bad_param
      $error("sipo: DATA_WIDTH must be >= 2 and DIRECTION msb_first or lsb_first");
    end
    if (DIRECTION == "lsb_first") begin : g_lsb_first
      assign shifted_c = {data_i, shreg_q[W-1:1]};
    end else begin : g_msb_first
      assign shifted_c = {shreg_q[W-2:0], data_i};
    end
  endgenerate

  // Next-state: clear beats an accepted bit; a completing word loads only into a free holder.
  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    vld_d       = vld_q;
    ovr_d       = ovr_q;

    accept_c    = en_i && data_valid_i && !clr_i;
    last_c      = (cnt_q == CW'(W - 1));
    word_done_c = accept_c && last_c;
    hold_free_c = !vld_q || ready_i;

    if (clr_i) begin
      shreg_d = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (accept_c) begin
      shreg_d = shifted_c;
      cnt_d   = last_c ? '0 : cnt_q + CW'(1);
    end

    if (vld_q && ready_i) begin
      vld_d = 1'b0;
    end

    if (word_done_c) begin
      if (hold_free_c) begin
        vld_d  = 1'b1;
        data_d = shifted_c;
      end else begin
        ovr_d  = 1'b1;
      end
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_valid_o = vld_q;
  assign data_o       = data_q;
  assign busy_o       = busy_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_sipo.sv
// Bench for sipo: one msb_first and one lsb_first instance receive the same words,
// each serialized in its own bit order; consumed words are checked against a scoreboard.
module tb_sipo;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic clr = 1'b0;
  logic dv  = 1'b0;
  logic dm  = 1'b0;
  logic dl  = 1'b0;
  logic rdy = 1'b1;

  logic         vld_m, vld_l, busy_m, busy_l, ovr_m, ovr_l;
  logic [W-1:0] data_m, data_l;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb_m[$];
  logic [W-1:0] sb_l[$];

  sipo #(.DATA_WIDTH(W), .DIRECTION("msb_first")) u_msb (
    .clk_i(clk), .a_rst_i(rst), .en_i(en), .clr_i(clr), .data_valid_i(dv), .data_i(dm),
    .ready_i(rdy), .data_valid_o(vld_m), .data_o(data_m), .busy_o(busy_m), .overrun_o(ovr_m)
  );

  sipo #(.DATA_WIDTH(W), .DIRECTION("lsb_first")) u_lsb (
    .clk_i(clk), .a_rst_i(rst), .en_i(en), .clr_i(clr), .data_valid_i(dv), .data_i(dl),
    .ready_i(rdy), .data_valid_o(vld_l), .data_o(data_l), .busy_o(busy_l), .overrun_o(ovr_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every consume (valid && ready before the edge) pops one expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld_m && rdy) begin
        if (sb_m.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_m_unexpected: got 0x%0h expected none", data_m);
        end else begin
          chk("sb_m_word", 32'(data_m), 32'(sb_m.pop_front()));
        end
      end
      if (vld_l && rdy) begin
        if (sb_l.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_l_unexpected: got 0x%0h expected none", data_l);
        end else begin
          chk("sb_l_word", 32'(data_l), 32'(sb_l.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = w[W-1-i];
    return r;
  endfunction

  task automatic push(input logic [W-1:0] w);
    sb_m.push_back(w);
    sb_l.push_back(w);
  endtask

  // Sequences list bits in send order, first bit at index W-1.
  task automatic send_bits(input logic [W-1:0] m_seq, input logic [W-1:0] l_seq,
                           input int lo, input int hi, input bit gap);
    for (int i = lo; i < hi; i++) begin
      if (gap && i > lo) begin
        dv = 1'b0; dm = ~dm; dl = ~dl;
        tick();
      end
      dv = 1'b1;
      dm = m_seq[W-1-i];
      dl = l_seq[W-1-i];
      tick();
    end
    dv = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int lo, input int hi);
    send_bits(w, bitrev(w), lo, hi, 1'b0);
  endtask

  task automatic chk_ctl(input string tag, input logic v, input logic ov, input logic b);
    chk({tag, "_m_valid"}, 32'(vld_m), 32'(v));
    chk({tag, "_l_valid"}, 32'(vld_l), 32'(v));
    chk({tag, "_m_overrun"}, 32'(ovr_m), 32'(ov));
    chk({tag, "_l_overrun"}, 32'(ovr_l), 32'(ov));
    chk({tag, "_m_busy"}, 32'(busy_m), 32'(b));
    chk({tag, "_l_busy"}, 32'(busy_l), 32'(b));
  endtask

  task automatic chk_data(input string tag, input logic [W-1:0] d);
    chk({tag, "_m_data"}, 32'(data_m), 32'(d));
    chk({tag, "_l_data"}, 32'(data_l), 32'(d));
  endtask

  typedef struct {
    logic [W-1:0] m_seq;
    logic [W-1:0] l_seq;
    bit           gap;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[7];
  logic [W-1:0] w;

  initial begin
    vecs[0] = '{8'b1011_0100, 8'b0010_1101, 1'b0, 8'hB4};
    vecs[1] = '{8'b1011_0100, 8'b0010_1101, 1'b1, 8'hB4};
    vecs[2] = '{8'b0000_0001, 8'b1000_0000, 1'b0, 8'h01};
    vecs[3] = '{8'b1000_0000, 8'b0000_0001, 1'b1, 8'h80};
    vecs[4] = '{8'b1111_1111, 8'b1111_1111, 1'b0, 8'hFF};
    vecs[5] = '{8'b0000_0000, 8'b0000_0000, 1'b0, 8'h00};
    vecs[6] = '{8'b1100_1010, 8'b0101_0011, 1'b1, 8'hCA};

    tick(); tick();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk_data("reset", 8'h00);
    rst = 1'b0;
    tick();

    // Single words, ready high: valid for exactly one cycle after the last bit.
    rdy = 1'b1;
    foreach (vecs[k]) begin
      push(vecs[k].exp);
      send_bits(vecs[k].m_seq, vecs[k].l_seq, 0, int'(W), vecs[k].gap);
      chk_ctl($sformatf("vec%0d_out", k), 1'b1, 1'b0, 1'b0);
      chk_data($sformatf("vec%0d_out", k), vecs[k].exp);
      tick();
      chk_ctl($sformatf("vec%0d_after", k), 1'b0, 1'b0, 1'b0);
    end

    // en_i low: qualified bits are ignored.
    en = 1'b0; dv = 1'b1; dm = 1'b1; dl = 1'b1;
    tick(); tick();
    chk_ctl("en_low", 1'b0, 1'b0, 1'b0);
    en = 1'b1; dv = 1'b0;
    push(8'h96);
    send_word(8'h96, 0, int'(W));
    chk_data("en_resume", 8'h96);
    tick();

    // Backpressure: second word dropped, overrun set, then consume and clear.
    rdy = 1'b0;
    push(8'h11);
    send_word(8'h11, 0, int'(W));
    chk_ctl("bp_first", 1'b1, 1'b0, 1'b0);
    chk_data("bp_first", 8'h11);
    send_word(8'h22, 0, int'(W));
    chk_ctl("bp_drop", 1'b1, 1'b1, 1'b0);
    chk_data("bp_drop", 8'h11);
    rdy = 1'b1;
    tick();
    chk_ctl("bp_consumed", 1'b0, 1'b1, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_ctl("bp_clr", 1'b0, 1'b0, 1'b0);

    // Word completes in the same cycle the pending word is consumed.
    rdy = 1'b0;
    push(8'h11);
    send_word(8'h11, 0, int'(W));
    push(8'h22);
    send_word(8'h22, 0, int'(W) - 1);
    rdy = 1'b1;
    send_word(8'h22, int'(W) - 1, int'(W));
    chk_ctl("simul", 1'b1, 1'b0, 1'b0);
    chk_data("simul", 8'h22);
    tick();
    chk_ctl("simul_after", 1'b0, 1'b0, 1'b0);

    // clr_i with a 4th bit drops the partial word completely.
    send_word(8'hFF, 0, 3);
    chk_ctl("clr_partial", 1'b0, 1'b0, 1'b1);
    dv = 1'b1; dm = 1'b1; dl = 1'b1; clr = 1'b1;
    tick();
    dv = 1'b0; clr = 1'b0;
    chk_ctl("clr_pulse", 1'b0, 1'b0, 1'b0);
    push(8'hC3);
    send_word(8'hC3, 0, int'(W));
    chk_ctl("clr_word", 1'b1, 1'b0, 1'b0);
    chk_data("clr_word", 8'hC3);
    tick();

    // Asynchronous reset mid-word with a pending word: everything clears before any edge.
    rdy = 1'b0;
    send_word(8'h5A, 0, int'(W));
    send_word(8'hFF, 0, 3);
    chk_ctl("pre_rst", 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_ctl("async_rst", 1'b0, 1'b0, 1'b0);
    chk_data("async_rst", 8'h00);
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    tick();
    chk_ctl("post_rst", 1'b0, 1'b0, 1'b0);

    // Loopback: 256 random words back-to-back in both bit orders.
    for (int n = 0; n < 256; n++) begin
      w = W'($urandom);
      push(w);
      send_word(w, 0, int'(W));
      chk({"loop_m_overrun"}, 32'(ovr_m), 32'(0));
      chk({"loop_l_overrun"}, 32'(ovr_l), 32'(0));
    end
    tick(); tick();
    chk("sb_m_drain", 32'(sb_m.size()), 32'(0));
    chk("sb_l_drain", 32'(sb_l.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
